// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, receiver/transmitter state encodings and bit timing.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StCleanup  = 3'd4,
        StWaitHigh = 3'd5
    } rx_state_e;

    typedef enum logic [2:0] {
        TxIdle    = 3'd0,
        TxStart   = 3'd1,
        TxData    = 3'd2,
        TxStop    = 3'd3,
        TxCleanup = 3'd4
    } tx_state_e;

    // Count at which the start bit is re-checked, i.e. roughly mid-bit.
    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line input and received-data outputs of the UART receiver.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 i_RX_Serial;
    logic                 o_RX_DV;
    logic [DATA_BITS-1:0] o_RX_Byte;
    logic                 o_RX_Framing_Err;
    logic                 o_RX_Active;

    modport master (
        input  i_RX_Serial,
        output o_RX_DV,
        output o_RX_Byte,
        output o_RX_Framing_Err,
        output o_RX_Active
    );

    modport slave (
        output i_RX_Serial,
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_RX_Framing_Err,
        input  o_RX_Active
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module uart_rx_sync #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             i_Clock,
    input  logic             i_Rst_L,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    assign synced = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, qualifies the start bit and samples bits mid-bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic      i_Clock,
    input  logic      i_Rst_L,
    uart_rx_if.master bus
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 dv_q, dv_d;
    logic                 ferr_q, ferr_d;
    logic                 active_q, active_d;

    // Reset value 1 keeps reset release from looking like a start bit.
    uart_rx_sync #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_sync (
        .i_Clock(i_Clock),
        .i_Rst_L(i_Rst_L),
        .raw    (bus.i_RX_Serial),
        .synced (rx_s)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
        active_d = active_q;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        active_d = 1'b1;
                        state_d  = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StData: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == LAST_IDX) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StStop: begin
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = StCleanup;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StCleanup: begin
                state_d = StIdle;
            end

            // A held-low line (break) waits here without further strobes.
            StWaitHigh: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.o_RX_DV          = dv_q;
    assign bus.o_RX_Byte        = byte_q;
    assign bus.o_RX_Framing_Err = ferr_q;
    assign bus.o_RX_Active      = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: a sample-point model over the recorded line checks every cycle.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int NDUT = 2;
    localparam int CPB0 = 8;
    localparam int CPB1 = 434;
    localparam int HIST = 131072;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } lit_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pin [NDUT];
    int   cyc   = 0;
    bit   pin_hist [NDUT][HIST];

    int   checks = 0;
    int   errors = 0;
    int   exp_dv_n [NDUT] = '{0, 0};
    int   exp_fe_n [NDUT] = '{0, 0};
    lit_t lit_q0 [$];
    lit_t lit_q1 [$];
    bit   end_req = 1'b0;
    bit   end_ack = 1'b0;

    always #5 clk = ~clk;

    uart_rx_if bus0 ();
    uart_rx_if bus1 ();

    assign bus0.i_RX_Serial = pin[0];
    assign bus1.i_RX_Serial = pin[1];

    uart_rx #(.CLKS_PER_BIT(CPB0)) dut0 (
        .i_Clock(clk),
        .i_Rst_L(rst_n),
        .bus    (bus0)
    );

    uart_rx #(.CLKS_PER_BIT(CPB1)) dut1 (
        .i_Clock(clk),
        .i_Rst_L(rst_n),
        .bus    (bus1)
    );

    // Line value as seen by the synchroniser at each edge; reset holds it at idle.
    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (cyc < HIST) pin_hist[g][cyc] = rst_n ? pin[g] : 1'b1;
        end
        cyc = cyc + 1;
    end

    // Model: the line is sampled 2 edges late; from the first low sample n, the start bit is
    // re-checked at n+HALF+1, bit k at n+HALF+1+(k+1)*CPB and the stop bit at n+HALF+1+9*CPB.
    int         m_mode  [NDUT];
    int         m_n     [NDUT];
    int         m_from  [NDUT];
    logic [7:0] m_shift [NDUT];
    logic [7:0] m_byte  [NDUT];
    logic       m_act   [NDUT];
    int         dv_seen [NDUT] = '{0, 0};
    int         fe_seen [NDUT] = '{0, 0};
    int         last_dv [NDUT] = '{0, 0};

    always @(negedge clk) begin
        logic       dv, fe, act, e_dv, e_fe, v, have;
        logic [7:0] byt;
        int         cpb, h, p, rel, k, e;
        lit_t       lit;
        e = cyc - 1;
        for (int g = 0; g < NDUT; g++) begin
            if (g == 0) begin
                dv = bus0.o_RX_DV; fe = bus0.o_RX_Framing_Err;
                act = bus0.o_RX_Active; byt = bus0.o_RX_Byte;
                cpb = CPB0;
            end else begin
                dv = bus1.o_RX_DV; fe = bus1.o_RX_Framing_Err;
                act = bus1.o_RX_Active; byt = bus1.o_RX_Byte;
                cpb = CPB1;
            end
            h    = (cpb - 1) / 2;
            e_dv = 1'b0;
            e_fe = 1'b0;
            if (!rst_n) begin
                m_mode[g] = 0;
                m_from[g] = 0;
                m_act[g]  = 1'b0;
                m_byte[g] = 8'h00;
            end else begin
                p = e - 2;
                v = (p >= 0) ? pin_hist[g][p] : 1'b1;
                case (m_mode[g])
                    0: if (p >= m_from[g] && !v) begin
                        m_n[g]    = p;
                        m_mode[g] = 1;
                    end
                    1: begin
                        rel = p - m_n[g] - h - 1;
                        if (rel == 0) begin
                            if (v) m_mode[g] = 0;
                            else m_act[g] = 1'b1;
                        end else if (rel > 0 && rel % cpb == 0) begin
                            k = rel / cpb - 1;
                            if (k < 8) begin
                                m_shift[g][k] = v;
                            end else begin
                                m_act[g] = 1'b0;
                                if (v) begin
                                    e_dv      = 1'b1;
                                    m_byte[g] = m_shift[g];
                                    m_mode[g] = 0;
                                    m_from[g] = p + 2;
                                end else begin
                                    e_fe      = 1'b1;
                                    m_mode[g] = 2;
                                end
                            end
                        end
                    end
                    default: if (v) m_mode[g] = 0;
                endcase
            end

            checks++;
            if (dv !== e_dv || fe !== e_fe || act !== m_act[g] || byt !== m_byte[g]) begin
                errors++;
                $display("FAIL outputs dut%0d cyc %0d: dv=%b fe=%b act=%b byte=%h, expected dv=%b fe=%b act=%b byte=%h",
                         g, e, dv, fe, act, byt, e_dv, e_fe, m_act[g], m_byte[g]);
            end

            if (fe === 1'b1) fe_seen[g]++;
            if (dv === 1'b1) begin
                dv_seen[g]++;
                have = 1'b0;
                if (g == 0 && lit_q0.size() > 0) begin lit = lit_q0.pop_front(); have = 1'b1; end
                if (g == 1 && lit_q1.size() > 0) begin lit = lit_q1.pop_front(); have = 1'b1; end
                if (have) begin
                    checks++;
                    if (byt !== lit.data || (lit.gap != 0 && e - last_dv[g] != lit.gap)) begin
                        errors++;
                        $display("FAIL literal dut%0d cyc %0d: byte=%h gap=%0d, expected byte=%h gap=%0d",
                                 g, e, byt, e - last_dv[g], lit.data, lit.gap);
                    end
                end
                last_dv[g] = e;
            end
        end

        if (end_req && !end_ack) begin
            for (int g = 0; g < NDUT; g++) begin
                checks++;
                if (dv_seen[g] != exp_dv_n[g]) begin
                    errors++;
                    $display("FAIL dv_count dut%0d: got %0d, expected %0d", g, dv_seen[g], exp_dv_n[g]);
                end
                checks++;
                if (fe_seen[g] != exp_fe_n[g]) begin
                    errors++;
                    $display("FAIL ferr_count dut%0d: got %0d, expected %0d", g, fe_seen[g], exp_fe_n[g]);
                end
            end
            checks++;
            if (lit_q0.size() + lit_q1.size() != 0) begin
                errors++;
                $display("FAIL literal_pending: %0d bytes never strobed, expected 0",
                         lit_q0.size() + lit_q1.size());
            end
            end_ack = 1'b1;
        end
    end

    task automatic expect_byte(input int g, input logic [7:0] data, input int gap);
        lit_t l;
        l.data = data;
        l.gap  = gap;
        if (g == 0) lit_q0.push_back(l);
        else lit_q1.push_back(l);
        exp_dv_n[g]++;
    endtask

    // Drives the first nbits of {stop, data, start} LSB first, each bitlen cycles long.
    task automatic send_frame(input int g, input logic [7:0] data, input logic stop_bit,
                              input int bitlen, input int nbits);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            pin[g] = bits[i];
            repeat (bitlen) @(negedge clk);
        end
    endtask

    task automatic idle(input int g, input int n);
        pin[g] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        pin[0] = 1'b1;
        pin[1] = 1'b1;
        rst_n  = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(0, 20);

        expect_byte(0, 8'hA5, 0);
        send_frame(0, 8'hA5, 1'b1, CPB0, 10);
        idle(0, 20);

        expect_byte(0, 8'h00, 0);
        expect_byte(0, 8'hFF, 80);
        expect_byte(0, 8'h81, 80);
        send_frame(0, 8'h00, 1'b1, CPB0, 10);
        send_frame(0, 8'hFF, 1'b1, CPB0, 10);
        send_frame(0, 8'h81, 1'b1, CPB0, 10);
        idle(0, 20);

        pin[0] = 1'b0;
        repeat (2) @(negedge clk);
        idle(0, 30);

        exp_fe_n[0]++;
        send_frame(0, 8'h3C, 1'b0, CPB0, 10);
        pin[0] = 1'b0;
        repeat (3 * 10 * CPB0) @(negedge clk);
        idle(0, 20);
        expect_byte(0, 8'h55, 0);
        send_frame(0, 8'h55, 1'b1, CPB0, 10);
        idle(0, 20);

        // Abort 8'hC3 with reset while its data bit 4 is on the line.
        send_frame(0, 8'hC3, 1'b1, CPB0, 5);
        pin[0] = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        pin[0] = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(0, 20);
        expect_byte(0, 8'h12, 0);
        send_frame(0, 8'h12, 1'b1, CPB0, 10);
        idle(0, 20);

        expect_byte(1, 8'h55, 0);
        expect_byte(1, 8'hAA, 0);
        send_frame(1, 8'h55, 1'b1, 447, 10);
        send_frame(1, 8'hAA, 1'b1, 421, 10);
        idle(1, 50);

        for (int i = 0; i < 150; i++) begin
            int         kind;
            logic [7:0] b;
            kind = $urandom_range(0, 9);
            b    = 8'($urandom);
            if (kind == 0) begin
                pin[0] = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                idle(0, $urandom_range(8, 15));
            end else if (kind == 1) begin
                exp_fe_n[0]++;
                send_frame(0, b, 1'b0, CPB0, 10);
                pin[0] = 1'b0;
                repeat ($urandom_range(0, 20)) @(negedge clk);
                idle(0, $urandom_range(1, 10));
            end else begin
                exp_dv_n[0]++;
                send_frame(0, b, 1'b1, CPB0, 10);
                idle(0, $urandom_range(0, 5));
            end
        end
        idle(0, 30);

        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp_dv_n[1]++;
            send_frame(1, b, 1'b1, $urandom_range(425, 443), 10);
        end
        idle(1, 100);

        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for 8N1 asynchronous serial: 8 data bits LSB first, one start bit, one stop bit, no parity. It synchronises the raw RX pin into `i_Clock`, detects and qualifies the start bit, and samples each bit at mid-bit. It presents the received byte with a one-cycle valid strobe, or flags a framing error. It is the receive counterpart of the design's UART transmitter, and both blocks use the same `CLKS_PER_BIT` for a given baud rate.

## Interface
- `CLKS_PER_BIT`, default 434: i_Clock cycles per bit, equal to f_clk / baud. Legal values are 4 or more.
- `i_Clock`  in  1  system clock.
- `i_Rst_L`  in  1  reset, asynchronous, active-low.
- `i_RX_Serial`  in  1  raw serial line, asynchronous to i_Clock, idle high.
- `o_RX_DV`  out  1  one-cycle strobe: o_RX_Byte is valid.
- `o_RX_Byte`  out  8  last good byte received; holds its value until the next good byte.
- `o_RX_Framing_Err`  out  1  one-cycle strobe: stop bit sampled low.
- `o_RX_Active`  out  1  high from start-bit qualification until the frame completes.

## Operation
- **Input sync:** 2-flop synchroniser on i_RX_Serial.
  - Both flops reset to 1, so reset release never produces a false start.
  - All logic below uses the synchronised signal `rx_s`.
- **Bit counter:** r_Clock_Count, width $clog2(CLKS_PER_BIT)+1. Bit index is 3 bits.
- **IDLE:**
  - Clears the counter and bit index.
  - When rx_s == 0: goes to START.
- **START:**
  - Counts up to HALF = (CLKS_PER_BIT-1)/2 (integer division).
  - At count == HALF, if rx_s == 0: sets o_RX_Active=1, clears the counter, goes to DATA.
  - At count == HALF, if rx_s == 1: treats it as a glitch and returns to IDLE with no output activity.
- **DATA:**
  - Counts to CLKS_PER_BIT-1.
  - At that count, samples rx_s into shift register bit [index] and clears the counter.
  - Index 0..6: increments the index.
  - Index 7: goes to STOP.
- **STOP:**
  - Counts to CLKS_PER_BIT-1, then samples rx_s.
  - rx_s == 1: loads o_RX_Byte from the shift register, pulses o_RX_DV, goes to CLEANUP.
  - rx_s == 0: pulses o_RX_Framing_Err, leaves o_RX_Byte unchanged, goes to WAIT_HIGH.
  - In both cases, o_RX_Active drops in the same cycle as the strobe.
- **WAIT_HIGH:**
  - Stays here while rx_s == 0. This covers break conditions, which produce no further strobes.
  - Goes to IDLE on the first rx_s == 1.
- **CLEANUP:**
  - One cycle, strobe deasserted, then IDLE.
- **Back-to-back frames:** a start bit may immediately follow a stop bit. Because stop sampling occurs mid-bit, IDLE is re-entered before the next falling edge arrives.
- **Illegal state encoding:** returns to IDLE.

## Timing
- **Reset values:**
  - o_RX_DV=0, o_RX_Byte=8'h00, o_RX_Framing_Err=0, o_RX_Active=0.
  - State IDLE; counters 0; sync flops 1.
  - The asynchronous assert aborts any frame in progress. No strobe is issued on or after reset.
- **Sync latency:** rx_s lags the pin by 2 cycles.
- **Sample points:** measured from the first cycle rx_s is low (IDLE→START transition).
  - Start qualification at +HALF+1 cycles.
  - Data bit k sampled at +HALF+1+(k+1)·CLKS_PER_BIT.
  - Stop bit sampled at +HALF+1+9·CLKS_PER_BIT.
- **Strobe timing:** o_RX_DV or o_RX_Framing_Err is registered high in the cycle after the stop sample, for exactly one cycle. The two are never high together.
- **Strobe spacing:** minimum distance between two o_RX_DV strobes is 10·CLKS_PER_BIT cycles, at line rate.

## Structure
- **Shared package `uart_pkg`:**
  - State encoding constants: IDLE, START, DATA, STOP, CLEANUP, WAIT_HIGH.
  - Frame constants: DATA_BITS=8, STOP_BITS=1.
  - The transmitter's encodings move into the same package.
- **Sub-module `uart_rx_sync`:**
  - Parameterised 2-flop synchroniser with a reset value parameter (here 1).
  - Reusable for other asynchronous inputs.

## Test plan
- **Nominal byte:** CLKS_PER_BIT=8, loop back from the transmitter sending 8'hA5 → one o_RX_DV with o_RX_Byte=8'hA5, no framing error, o_RX_Active low afterwards.
- **Back-to-back:** transmitter sends 8'h00, 8'hFF, 8'h81 with no idle gap → three o_RX_DV strobes, 80 cycles apart, bytes in order.
- **Glitch rejection:** pin low for 2 cycles then high, CLKS_PER_BIT=8 → no strobe, o_RX_Active never rises, state back to IDLE.
- **Framing error:** drive 8'h3C with the stop bit low → o_RX_Framing_Err pulses once, o_RX_DV stays 0, o_RX_Byte keeps its previous value.
  - Then hold the line low for 3 frames → no further strobes.
  - Then release high and send 8'h55 → o_RX_DV with 8'h55.
- **Reset mid-frame:** assert i_Rst_L low during data bit 4 of 8'hC3 → outputs return to reset values immediately.
  - Release with the line idle → no strobe.
  - Next frame 8'h12 is received correctly.
- **Baud tolerance:** CLKS_PER_BIT=434, with the stimulus bit period at 434·(1±0.03) for bytes 8'h55 and 8'hAA → both received correctly.
